// File: rtl/data_memory_unit.sv
// data_memory_unit: byte-lane RAM with LED, switch and timer registers mapped into the top 16 bytes.
// Define DMEM_TIMER_EN to build the timer; otherwise the TIMER word reads 0 and timer_irq is 0.
module data_memory_unit #(
    parameter int         RAM_WORDS   = 60,
    parameter logic [7:0] MMIO_BASE   = 8'hF0,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  access_address,
    input  logic [7:0]  data_write,
    input  logic [3:0]  byte_enable,
    input  logic        write_enable,
    output logic [31:0] data_read,
    input  logic [7:0]  switch_in,
    output logic [7:0]  led_out,
    output logic        timer_irq
);
    localparam logic [6:0] RAM_LIMIT = 7'(RAM_WORDS);
    logic [5:0]  idx;
    logic [1:0]  off;
    logic        mmio, ram_hit, mmio_wr;
    logic [31:0] mem [RAM_WORDS];
    logic [SYNC_STAGES-1:0][7:0] sync;
    logic [31:0] timer_word, rd_word;
    logic        unused_addr_bits;
    assign idx              = access_address[7:2];
    assign off              = access_address[3:2];
    assign mmio             = access_address[7:4] == MMIO_BASE[7:4];
    assign ram_hit          = !mmio && ({1'b0, idx} < RAM_LIMIT);
    assign mmio_wr          = write_enable && mmio;
    assign unused_addr_bits = &{1'b0, access_address[1:0]};
    always_ff @(posedge clk) begin
        if (write_enable && ram_hit)
            for (int k = 0; k < 4; k++)
                if (byte_enable[k]) mem[idx][8*k +: 8] <= data_write;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= '0;
        end else begin
            sync[0] <= switch_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
        end
    end
`ifdef DMEM_TIMER_EN
    logic [7:0] count, compare;
    logic [2:0] ctrl;
    logic       match, timer_wr, hit;
    assign timer_wr   = mmio_wr && off == 2'd2;
    assign hit        = ctrl[0] && count == compare;
    assign timer_word = {7'b0, match, 5'b0, ctrl, compare, count};
    assign timer_irq  = match & ctrl[2];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            compare <= '0;
            ctrl    <= '0;
            match   <= 1'b0;
        end else begin
            if (ctrl[0]) count <= (hit && ctrl[1]) ? 8'd0 : count + 8'd1;
            if (timer_wr && byte_enable[1]) compare <= data_write;
            if (timer_wr && byte_enable[2]) ctrl <= data_write[2:0];
            // a hardware match in the same cycle as a W1C keeps the flag set
            match <= hit | (match & ~(timer_wr & byte_enable[3] & data_write[0]));
        end
    end
`else
    assign timer_word = '0;
    assign timer_irq  = 1'b0;
`endif
    assign rd_word = mmio ? (off == 2'd0 ? {24'b0, led_out} :
                             off == 2'd1 ? {24'b0, sync[SYNC_STAGES-1]} :
                             off == 2'd2 ? timer_word : 32'b0)
                          : (ram_hit ? mem[idx] : 32'b0);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_read <= '0;
            led_out   <= '0;
        end else begin
            data_read <= rd_word;
            if (mmio_wr && off == 2'd0 && byte_enable[0]) led_out <= data_write;
        end
    end
endmodule

// File: tb/tb_data_memory_unit.sv
// tb_data_memory_unit: directed checks of RAM lanes, MMIO registers, timer and reset behaviour.
module tb_data_memory_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  access_address = '0;
    logic [7:0]  data_write = '0;
    logic [3:0]  byte_enable = '0;
    logic        write_enable = 1'b0;
    logic [31:0] data_read;
    logic [7:0]  switch_in = '0;
    logic [7:0]  led_out;
    logic        timer_irq;
    int total = 0;
    int bad = 0;

    // RAM_WORDS reduced so that words 56..59 form an unmapped hole below MMIO
    data_memory_unit #(.RAM_WORDS(56)) dut (
        .clk(clk), .reset(reset), .access_address(access_address), .data_write(data_write),
        .byte_enable(byte_enable), .write_enable(write_enable), .data_read(data_read),
        .switch_in(switch_in), .led_out(led_out), .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic [3:0] be);
        access_address = a; data_write = d; byte_enable = be; write_enable = 1'b1;
        tick();
        write_enable = 1'b0; byte_enable = '0;
    endtask

    task automatic rd(input logic [7:0] a);
        access_address = a; write_enable = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) tick();
        total++; if (data_read !== 32'h0) begin bad++; $display("FAIL reset_data_read got=%h exp=%h", data_read, 32'h0); end
        total++; if (led_out !== 8'h0) begin bad++; $display("FAIL reset_led got=%h exp=%h", led_out, 8'h0); end
        total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=%b", timer_irq, 1'b0); end
        reset = 1'b1;
        rd(8'hF8);
        total++; if (data_read !== 32'h0) begin bad++; $display("FAIL reset_timer_word got=%h exp=%h", data_read, 32'h0); end
    endtask

    task automatic test_ram_write();
        wr(8'h08, 8'hA5, 4'b1111);
        rd(8'h08);
        total++; if (data_read !== 32'hA5A5A5A5) begin bad++; $display("FAIL ram_full_word got=%h exp=%h", data_read, 32'hA5A5A5A5); end
        wr(8'hDC, 8'h77, 4'b1111);
        rd(8'hDC);
        total++; if (data_read !== 32'h77777777) begin bad++; $display("FAIL ram_last_word got=%h exp=%h", data_read, 32'h77777777); end
    endtask

    task automatic test_byte_lane();
        wr(8'h08, 8'h00, 4'b1111);
        wr(8'h09, 8'h3C, 4'b0010);
        total++; if (data_read !== 32'h0) begin bad++; $display("FAIL rdw_old_word got=%h exp=%h", data_read, 32'h0); end
        rd(8'h08);
        total++; if (data_read !== 32'h00003C00) begin bad++; $display("FAIL lane1_write got=%h exp=%h", data_read, 32'h00003C00); end
        wr(8'h08, 8'h99, 4'b0000);
        rd(8'h08);
        total++; if (data_read !== 32'h00003C00) begin bad++; $display("FAIL be_zero got=%h exp=%h", data_read, 32'h00003C00); end
    endtask

    task automatic test_mmio_led_sw();
        wr(8'hF0, 8'h81, 4'b1111);
        total++; if (led_out !== 8'h81) begin bad++; $display("FAIL led_write got=%h exp=%h", led_out, 8'h81); end
        rd(8'hF0);
        total++; if (data_read !== 32'h00000081) begin bad++; $display("FAIL led_read got=%h exp=%h", data_read, 32'h00000081); end
        switch_in = 8'h5A;
        rd(8'hF4);
        rd(8'hF4);
        total++; if (data_read !== 32'h0) begin bad++; $display("FAIL sw_too_early got=%h exp=%h", data_read, 32'h0); end
        rd(8'hF4);
        total++; if (data_read !== 32'h0000005A) begin bad++; $display("FAIL sw_sync got=%h exp=%h", data_read, 32'h0000005A); end
        wr(8'hF4, 8'h00, 4'b1111);
        rd(8'hF4);
        total++; if (data_read !== 32'h0000005A) begin bad++; $display("FAIL sw_readonly got=%h exp=%h", data_read, 32'h0000005A); end
    endtask

    task automatic test_timer();
`ifdef DMEM_TIMER_EN
        wr(8'hF8, 8'h05, 4'b0010);
        wr(8'hF8, 8'h07, 4'b0100);
        access_address = 8'hF8;
        repeat (5) tick();
        total++; if (data_read !== 32'h00070504) begin bad++; $display("FAIL timer_count4 got=%h exp=%h", data_read, 32'h00070504); end
        total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL timer_irq_early got=%b exp=%b", timer_irq, 1'b0); end
        tick();
        total++; if (timer_irq !== 1'b1) begin bad++; $display("FAIL timer_irq_set got=%b exp=%b", timer_irq, 1'b1); end
        total++; if (data_read !== 32'h00070505) begin bad++; $display("FAIL timer_count5 got=%h exp=%h", data_read, 32'h00070505); end
        tick();
        total++; if (data_read !== 32'h01070500) begin bad++; $display("FAIL timer_autoclear got=%h exp=%h", data_read, 32'h01070500); end
        wr(8'hF8, 8'h01, 4'b1000);
        total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL timer_w1c got=%b exp=%b", timer_irq, 1'b0); end
        total++; if (data_read !== 32'h01070501) begin bad++; $display("FAIL timer_count_wrap got=%h exp=%h", data_read, 32'h01070501); end
        wr(8'hF8, 8'h00, 4'b0100);
`else
        wr(8'hF8, 8'hFF, 4'b1111);
        rd(8'hF8);
        total++; if (data_read !== 32'h0) begin bad++; $display("FAIL timer_absent_read got=%h exp=%h", data_read, 32'h0); end
        total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL timer_absent_irq got=%b exp=%b", timer_irq, 1'b0); end
`endif
    endtask

    task automatic test_unmapped();
        wr(8'hFC, 8'hFF, 4'b1111);
        rd(8'hFC);
        total++; if (data_read !== 32'h0) begin bad++; $display("FAIL reserved_read got=%h exp=%h", data_read, 32'h0); end
        wr(8'hE0, 8'hFF, 4'b1111);
        rd(8'hE0);
        total++; if (data_read !== 32'h0) begin bad++; $display("FAIL oob_read got=%h exp=%h", data_read, 32'h0); end
        total++; if (led_out !== 8'h81) begin bad++; $display("FAIL unmapped_led got=%h exp=%h", led_out, 8'h81); end
        rd(8'h08);
        total++; if (data_read !== 32'h00003C00) begin bad++; $display("FAIL unmapped_ram got=%h exp=%h", data_read, 32'h00003C00); end
    endtask

    task automatic test_mid_reset();
        wr(8'hF0, 8'hFF, 4'b0001);
        wr(8'hF8, 8'h01, 4'b0100);
        rd(8'h08);
        rd(8'h08);
        reset = 1'b0;
        #2;
        total++; if (led_out !== 8'h0) begin bad++; $display("FAIL midreset_led got=%h exp=%h", led_out, 8'h0); end
        total++; if (data_read !== 32'h0) begin bad++; $display("FAIL midreset_data got=%h exp=%h", data_read, 32'h0); end
        total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL midreset_irq got=%b exp=%b", timer_irq, 1'b0); end
        tick();
        reset = 1'b1;
        rd(8'hF8);
        total++; if (data_read !== 32'h0) begin bad++; $display("FAIL midreset_timer got=%h exp=%h", data_read, 32'h0); end
    endtask

    initial begin
        test_reset();
        test_ram_write();
        test_byte_lane();
        test_mmio_led_sw();
        test_timer();
        test_unmapped();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/data_memory_unit.md
Name: data_memory_unit

Overview:
Data-side memory stage that sits directly downstream of the 8-bit pipelined processor's memory port. It consumes access_address, data_write, byte_enable and write_enable, and returns a 32-bit data_read word.
- Backing store: 60-word x 32-bit RAM with per-byte write lanes.
- Top 16 bytes of the address space: small memory-mapped I/O block (LED register, synchronized switch input, 8-bit timer with compare/interrupt).

Parameters:
RAM_WORDS, 60, number of 32-bit RAM words (word index 0..RAM_WORDS-1); must be <= 60
MMIO_BASE, 8'hF0, byte address of first MMIO word; MMIO decode uses access_address[7:4] == MMIO_BASE[7:4]
SYNC_STAGES, 2, flip-flop stages on switch_in

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset
access_address  input  8  byte address; word index = access_address[7:2]
data_write  input  8  store byte; written to every lane selected by byte_enable
byte_enable  input  4  lane select; bit k = bits [8k+7:8k]
write_enable  input  1  store strobe, sampled on rising edge
data_read  output  32  registered read word
switch_in  input  8  asynchronous external switches
led_out  output  8  LED register value
timer_irq  output  1  timer interrupt, level

Behaviour:
Reset (reset low, asynchronous):
- data_read=0, led_out=0, timer count/compare/control/status=0, sync flops=0, timer_irq=0.
- RAM contents are not reset.

Reads:
- data_read <= word selected by access_address[7:2] on every rising edge, regardless of write_enable; 1-cycle latency.
- Read-during-write to the same word returns the OLD word.
- Addresses in RAM space with word index >= RAM_WORDS (below MMIO) read 0.

RAM writes:
- On rising edge with write_enable=1 and RAM address: for each k with byte_enable[k]=1, word[k-lane] <= data_write; other lanes unchanged.
- byte_enable=0 with write_enable=1: no change.
- Out-of-range RAM writes are ignored.

MMIO map (word offsets from MMIO_BASE):
- +0x0 LED:
  - lane0 R/W = led_out; upper lanes read 0, writes ignored.
- +0x4 SW:
  - read-only {24'b0, sw_sync}, where sw_sync is switch_in after SYNC_STAGES flops; writes ignored.
- +0x8 TIMER:
  - lane0 count: read-only.
  - lane1 compare: R/W.
  - lane2 control: bit0 enable, bit1 auto_clear, bit2 irq_en; bits 7:3 read 0.
  - lane3 status: bit0 match; write-1-to-clear.
- +0xC: reserved; reads 0, writes ignored.

Timer:
- enable=1: count increments by 1 each cycle, wrapping 8'hFF -> 8'h00. enable=0: count holds.
- Match: enable=1 and count==compare sets status.match the next edge.
  - If auto_clear=1, count goes to 0 on that same edge instead of incrementing.
- Hardware set and W1C of match in the same cycle: set wins.
- Writing control does not alter count.
- timer_irq = match & irq_en, registered from state (no combinational path from inputs).

Simultaneous events:
- A write to compare takes effect for the comparison of the following cycle.
- Mid-operation reset clears all registers immediately; a pending write in that cycle is lost.

Optional Feature:
Macro: DMEM_TIMER_EN
- Defined: timer, TIMER word and timer_irq behave as above.
- Undefined: no timer logic is synthesized; TIMER word reads 0, writes are ignored, timer_irq is tied 0.
- LED, SW and RAM behaviour are identical in both builds.

Test Plan:
1. Reset, then write 8'hA5 to addr 0x08 with byte_enable=4'b1111; read addr 0x08 -> data_read=32'hA5A5A5A5 one cycle after the address is presented.
2. Write 8'h3C to addr 0x09 with byte_enable=4'b0010 over a word holding 32'h00000000 -> read gives 32'h00003C00; same-cycle read of that word during the write returns 32'h00000000.
3. Write 8'h81 to 0xF0 lane0 -> led_out=8'h81 next cycle. Drive switch_in=8'h5A -> read 0xF4 returns 32'h0000005A no earlier than SYNC_STAGES+1 cycles later.
4. (DMEM_TIMER_EN) Set compare=8'h05 and control=8'b111 -> count reaches 5, status.match=1 and timer_irq=1 the next cycle, then count restarts at 0. W1C 8'h01 to lane3 -> timer_irq drops the next cycle.
5. Write to 0xFC and to an out-of-range RAM word -> reads return 0; no other state changes.
6. Assert reset mid-count with led_out=8'hFF -> led_out=0, count=0 and data_read=0 immediately, before the next clock edge.
